// File: rtl/dbf_pkg.sv
// Default widths, derived-width helpers and packed complex types for the beamformer.
package dbf_pkg;
    localparam int DBF_DW   = 16;
    localparam int DBF_WW   = 16;
    localparam int DBF_N_CH = 8;

    function automatic int prod_w(input int dw, input int ww);
        return dw + ww;
    endfunction

    // One growth bit for ac-bd / ad+bc, plus log2(N_CH) bits for the frame sum.
    function automatic int acc_w(input int dw, input int ww, input int n_ch);
        return dw + ww + 1 + $clog2(n_ch);
    endfunction

    typedef struct packed {
        logic signed [DBF_DW-1:0] re;
        logic signed [DBF_DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [DBF_WW-1:0] re;
        logic signed [DBF_WW-1:0] im;
    } wt_t;
endpackage

// File: rtl/dbf_cmul.sv
// Signed complex multiply p = d * w with a valid/tag sideband, full precision.
// Latency: 3 cycles (operand regs, partial products, combine).
// No backpressure: accepts one operand pair every clock.
module dbf_cmul
    import dbf_pkg::*;
#(
    parameter int DW = DBF_DW,
    parameter int WW = DBF_WW,
    parameter int TW = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [TW-1:0]           in_tag,
    input  logic signed [DW-1:0]    d_re,
    input  logic signed [DW-1:0]    d_im,
    input  logic signed [WW-1:0]    w_re,
    input  logic signed [WW-1:0]    w_im,
    output logic                    out_vld,
    output logic [TW-1:0]           out_tag,
    output logic signed [DW+WW:0]   p_re,
    output logic signed [DW+WW:0]   p_im
);
    localparam int PW = prod_w(DW, WW);

    logic                 v1, v2;
    logic [TW-1:0]        t1, t2;
    logic signed [DW-1:0] dre_r, dim_r;
    logic signed [WW-1:0] wre_r, wim_r;
    logic signed [PW-1:0] rr, ii, ri, ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            out_vld <= 1'b0;
            t1      <= '0;
            t2      <= '0;
            out_tag <= '0;
            dre_r   <= '0;
            dim_r   <= '0;
            wre_r   <= '0;
            wim_r   <= '0;
            rr      <= '0;
            ii      <= '0;
            ri      <= '0;
            ir      <= '0;
            p_re    <= '0;
            p_im    <= '0;
        end else begin
            v1    <= in_vld;
            t1    <= in_tag;
            dre_r <= d_re;
            dim_r <= d_im;
            wre_r <= w_re;
            wim_r <= w_im;

            v2 <= v1;
            t2 <= t1;
            rr <= PW'(dre_r) * PW'(wre_r);
            ii <= PW'(dim_r) * PW'(wim_r);
            ri <= PW'(dre_r) * PW'(wim_r);
            ir <= PW'(dim_r) * PW'(wre_r);

            out_vld <= v2;
            out_tag <= t2;
            p_re    <= (PW+1)'(rr) - (PW+1)'(ii);
            p_im    <= (PW+1)'(ri) + (PW+1)'(ir);
        end
    end
endmodule

// File: rtl/dbf_beam_acc.sv
// Weighted coherent sum of N_CH time-multiplexed complex samples into one beam sample per frame.
// Latency: m_valid 5 edges after the edge accepting the last channel sample.
// No backpressure: one sample per clock, gaps allowed; malformed framing flagged on err_frame.
module dbf_beam_acc
    import dbf_pkg::*;
#(
    parameter  int DW   = DBF_DW,
    parameter  int WW   = DBF_WW,
    parameter  int N_CH = DBF_N_CH,
    localparam int CW   = $clog2(N_CH),
    localparam int AW   = acc_w(DW, WW, N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic                 s_first,
    input  logic signed [DW-1:0] s_i,
    input  logic signed [DW-1:0] s_q,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_addr,
    input  logic signed [WW-1:0] wr_re,
    input  logic signed [WW-1:0] wr_im,
    input  logic                 wt_swap,
    output logic                 wt_bank,
    output logic                 m_valid,
    output logic signed [AW-1:0] m_i,
    output logic signed [AW-1:0] m_q,
    output logic                 err_frame
);
    localparam int            TW       = DW + WW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_CH - 1);

    logic [CW-1:0]        ch_cnt;
    logic                 swap_pend;
    logic signed [WW-1:0] bank_re [2][N_CH];
    logic signed [WW-1:0] bank_im [2][N_CH];

    logic          start, cont, is_last, swap_now, rd_bank;
    logic [CW-1:0] rd_idx;

    always_comb begin
        start    = s_valid && s_first;
        cont     = s_valid && !s_first && (ch_cnt != '0);
        is_last  = cont && (ch_cnt == LAST_IDX);
        rd_idx   = start ? '0 : ch_cnt;
        // The frame that consumes a pending swap already reads from the new bank.
        swap_now = start && (swap_pend || wt_swap);
        rd_bank  = wt_bank ^ swap_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt    <= '0;
            swap_pend <= 1'b0;
            wt_bank   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= s_valid && (s_first ? (ch_cnt != '0) : (ch_cnt == '0));
            if (start)
                ch_cnt <= CW'(1);
            else if (cont)
                ch_cnt <= is_last ? '0 : ch_cnt + CW'(1);
            if (swap_now) begin
                wt_bank   <= ~wt_bank;
                swap_pend <= 1'b0;
            end else if (wt_swap) begin
                swap_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < N_CH; c++) begin
                    bank_re[b][c] <= '0;
                    bank_im[b][c] <= '0;
                end
            end
        end else if (wr_en && (int'(wr_addr) < N_CH)) begin
            bank_re[!wt_bank][wr_addr] <= wr_re;
            bank_im[!wt_bank][wr_addr] <= wr_im;
        end
    end

    logic                 p_vld;
    logic [1:0]           p_tag;
    logic signed [TW-1:0] p_re, p_im;

    dbf_cmul #(.DW(DW), .WW(WW), .TW(2)) u_cmul (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (start || cont),
        .in_tag  ({start, is_last}),
        .d_re    (s_i),
        .d_im    (s_q),
        .w_re    (bank_re[rd_bank][rd_idx]),
        .w_im    (bank_im[rd_bank][rd_idx]),
        .out_vld (p_vld),
        .out_tag (p_tag),
        .p_re    (p_re),
        .p_im    (p_im)
    );

    logic                 acc_last, fin_vld;
    logic signed [AW-1:0] acc_re, acc_im, fin_re, fin_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re   <= '0;
            acc_im   <= '0;
            acc_last <= 1'b0;
            fin_re   <= '0;
            fin_im   <= '0;
            fin_vld  <= 1'b0;
            m_valid  <= 1'b0;
            m_i      <= '0;
            m_q      <= '0;
        end else begin
            acc_last <= p_vld && p_tag[0];
            if (p_vld) begin
                acc_re <= p_tag[1] ? AW'(p_re) : acc_re + AW'(p_re);
                acc_im <= p_tag[1] ? AW'(p_im) : acc_im + AW'(p_im);
            end
            fin_vld <= acc_last;
            if (acc_last) begin
                fin_re <= acc_re;
                fin_im <= acc_im;
            end
            // m_i/m_q change only together with m_valid and hold in between.
            m_valid <= fin_vld;
            if (fin_vld) begin
                m_i <= fin_re;
                m_q <= fin_im;
            end
        end
    end
endmodule

// File: tb/tb_dbf_beam_acc.sv
// Bench for dbf_beam_acc with N_CH=4: vector table, hand-written framing/swap/reset sequences, random frames vs a frame-sum model.
module tb_dbf_beam_acc;
    import dbf_pkg::*;

    localparam int DW = 16, WW = 16, N_CH = 4, CW = 2, AW = 35;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid = 1'b0, s_first = 1'b0;
    logic signed [DW-1:0] s_i = '0, s_q = '0;
    logic                 wr_en = 1'b0;
    logic [CW-1:0]        wr_addr = '0;
    logic signed [WW-1:0] wr_re = '0, wr_im = '0;
    logic                 wt_swap = 1'b0;
    logic                 wt_bank, m_valid, err_frame;
    logic signed [AW-1:0] m_i, m_q;

    always #5 clk = ~clk;

    dbf_beam_acc #(.DW(DW), .WW(WW), .N_CH(N_CH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_first(s_first), .s_i(s_i), .s_q(s_q),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im), .wt_swap(wt_swap),
        .wt_bank(wt_bank), .m_valid(m_valid), .m_i(m_i), .m_q(m_q), .err_frame(err_frame)
    );

    typedef struct { longint i; longint q; int e; } obs_t;
    typedef struct { longint i; longint q; } exp_t;
    typedef struct { cplx_t s; wt_t w; longint ei; longint eq; } vec_t;

    obs_t   outq[$];
    exp_t   expq[$];
    vec_t   tab[5];
    int     cyc = 0, err_seen = 0, last_acc = 0;
    int     n_chk = 0, n_fail = 0;

    // Reference state: weight banks, active bank, pending swap, current frame data.
    longint mw_re[2][N_CH], mw_im[2][N_CH];
    int     mbank = 0;
    bit     mpend = 1'b0;
    longint fd_i[N_CH], fd_q[N_CH];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (m_valid) outq.push_back('{longint'(m_i), longint'(m_q), cyc});
        if (err_frame) err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return longint'(v);
    endfunction

    task automatic wr_w(int ch, longint re, longint im);
        @(negedge clk);
        s_valid = 1'b0; s_first = 1'b0;
        wr_en = 1'b1; wr_addr = CW'(ch); wr_re = WW'(re); wr_im = WW'(im);
        mw_re[1-mbank][ch] = re;
        mw_im[1-mbank][ch] = im;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic swap();
        @(negedge clk);
        s_valid = 1'b0; s_first = 1'b0;
        wt_swap = 1'b1;
        mpend = 1'b1;
        @(negedge clk);
        wt_swap = 1'b0;
    endtask

    task automatic samp(bit f, longint i, longint q);
        @(negedge clk);
        s_valid = 1'b1; s_first = f; s_i = DW'(i); s_q = DW'(q);
        last_acc = cyc + 1;
        if (f && mpend) begin
            mbank = 1 - mbank;
            mpend = 1'b0;
        end
    endtask

    task automatic gap();
        @(negedge clk);
        s_valid = 1'b0; s_first = 1'b0;
    endtask

    task automatic send_frame(bit gaps);
        longint ei = 0, eq = 0;
        for (int ch = 0; ch < N_CH; ch++) begin
            samp(ch == 0, fd_i[ch], fd_q[ch]);
            if (gaps && ($urandom_range(0, 1) == 1)) gap();
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            ei += fd_i[ch] * mw_re[mbank][ch] - fd_q[ch] * mw_im[mbank][ch];
            eq += fd_i[ch] * mw_im[mbank][ch] + fd_q[ch] * mw_re[mbank][ch];
        end
        expq.push_back('{ei, eq});
    endtask

    task automatic drain_one(string nm, longint ei, longint eq, bit lat);
        obs_t o;
        repeat (10) @(negedge clk);
        chk({nm, " count"}, outq.size(), 1);
        if (outq.size() > 0) begin
            o = outq.pop_front();
            chk({nm, " m_i"}, o.i, ei);
            chk({nm, " m_q"}, o.q, eq);
            if (lat) chk({nm, " latency"}, o.e - last_acc, 5);
        end
        outq.delete();
        expq.delete();
    endtask

    task automatic drain_model(string nm);
        obs_t o;
        exp_t x;
        repeat (10) @(negedge clk);
        chk({nm, " count"}, outq.size(), expq.size());
        while (outq.size() > 0 && expq.size() > 0) begin
            o = outq.pop_front();
            x = expq.pop_front();
            chk({nm, " m_i"}, o.i, x.i);
            chk({nm, " m_q"}, o.q, x.q);
        end
        outq.delete();
        expq.delete();
    endtask

    task automatic set_vec(int n, int sr, int si, int wre, int wim, longint ei, longint eq);
        tab[n].s.re = 16'(sr);
        tab[n].s.im = 16'(si);
        tab[n].w.re = 16'(wre);
        tab[n].w.im = 16'(wim);
        tab[n].ei   = ei;
        tab[n].eq   = eq;
    endtask

    initial begin
        int b0, e0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < N_CH; c++) begin
                mw_re[b][c] = 0;
                mw_im[b][c] = 0;
            end

        set_vec(0,    100,    50,  16384,      0,  64'sd6553600,  64'sd3276800);
        set_vec(1,    100,    50,      0,  16384, -64'sd3276800,  64'sd6553600);
        set_vec(2, -32768, 32767, -32768, -32768,  64'sd8589803520, 64'sd131072);
        set_vec(3, -32768,-32768, -32768, -32768,  64'sd0,        64'sd8589934592);
        set_vec(4,      1,    -1,      3,      7,  64'sd40,       64'sd16);

        repeat (3) @(negedge clk);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_i", m_i, 0);
        chk("reset m_q", m_q, 0);
        chk("reset err_frame", err_frame, 0);
        chk("reset wt_bank", wt_bank, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (tab[n]) begin
            for (int ch = 0; ch < N_CH; ch++) wr_w(ch, tab[n].w.re, tab[n].w.im);
            swap();
            for (int ch = 0; ch < N_CH; ch++) begin
                fd_i[ch] = tab[n].s.re;
                fd_q[ch] = tab[n].s.im;
            end
            send_frame(1'b0);
            gap();
            drain_one($sformatf("vec%0d", n), tab[n].ei, tab[n].eq, n == 0);
            chk($sformatf("vec%0d wt_bank", n), wt_bank, mbank);
        end

        // Swap requested mid-frame must wait for the next frame start.
        for (int ch = 0; ch < N_CH; ch++) wr_w(ch, 16384, 0);
        swap();
        samp(1'b1, 100, 50);
        samp(1'b0, 100, 50);
        gap();
        b0 = mbank;
        for (int ch = 0; ch < N_CH; ch++) wr_w(ch, 0, 16384);
        swap();
        samp(1'b0, 100, 50);
        samp(1'b0, 100, 50);
        gap();
        chk("midswap bank held", wt_bank, b0);
        drain_one("midswap old", 64'sd6553600, 64'sd3276800, 1'b0);
        samp(1'b1, 100, 50);
        @(posedge clk); #1;
        chk("midswap bank toggled", wt_bank, 1 - b0);
        for (int ch = 1; ch < N_CH; ch++) samp(1'b0, 100, 50);
        gap();
        drain_one("midswap new", -64'sd3276800, 64'sd6553600, 1'b0);

        // Restarted frame, then a stray sample while idle.
        e0 = err_seen;
        samp(1'b1, 100, 50);
        samp(1'b0, 100, 50);
        for (int ch = 0; ch < N_CH; ch++) samp(ch == 0, 100, 50);
        gap();
        drain_one("restart", -64'sd3276800, 64'sd6553600, 1'b0);
        chk("restart err pulses", err_seen - e0, 1);
        samp(1'b0, 7, 7);
        gap();
        repeat (10) @(negedge clk);
        chk("stray err pulses", err_seen - e0, 2);
        chk("stray no output", outq.size(), 0);

        // Random weights and data, back-to-back frames with random gaps.
        for (int r = 0; r < 3; r++) begin
            for (int ch = 0; ch < N_CH; ch++) wr_w(ch, rnd16(), rnd16());
            swap();
            for (int f = 0; f < 4; f++) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    fd_i[ch] = rnd16();
                    fd_q[ch] = rnd16();
                end
                send_frame(1'b1);
            end
            gap();
        end
        drain_model("random");
        chk("random wt_bank", wt_bank, mbank);

        // Reset with one frame in the pipeline and another partially received.
        for (int ch = 0; ch < N_CH; ch++) begin
            fd_i[ch] = 100;
            fd_q[ch] = 50;
        end
        send_frame(1'b0);
        samp(1'b1, 100, 50);
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0; s_first = 1'b0;
        mbank = 0;
        mpend = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < N_CH; c++) begin
                mw_re[b][c] = 0;
                mw_im[b][c] = 0;
            end
        #1;
        chk("midrst m_valid", m_valid, 0);
        chk("midrst m_i", m_i, 0);
        chk("midrst m_q", m_q, 0);
        chk("midrst err_frame", err_frame, 0);
        chk("midrst wt_bank", wt_bank, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst no output", outq.size(), 0);
        outq.delete();
        expq.delete();
        send_frame(1'b0);
        gap();
        drain_one("post-reset cleared banks", 64'sd0, 64'sd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
